// File: rtl/parking_gate_arbiter_if.sv
// Request/response bundle between the lane sensors and the parking gate arbiter.
// master: lane side (drives requests); slave: arbiter side (drives door/status).
interface parking_gate_arbiter_if #(
  parameter int unsigned CNT_W = 4
);
  logic             entry_req;
  logic             exit_req;
  logic             door_open;
  logic             grant_entry;
  logic             grant_exit;
  logic             entry_reject;
  logic             busy;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output entry_req,
    output exit_req,
    input  door_open,
    input  grant_entry,
    input  grant_exit,
    input  entry_reject,
    input  busy,
    input  full,
    input  empty,
    input  occupancy
  );

  modport slave (
    input  entry_req,
    input  exit_req,
    output door_open,
    output grant_entry,
    output grant_exit,
    output entry_reject,
    output busy,
    output full,
    output empty,
    output occupancy
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Parking gate arbiter: shares one door between the entry and exit lanes, issues one
// open pulse per granted vehicle, holds off grants for the door window and tracks
// occupancy against capacity.
// Optional build macro PARKING_GATE_EXIT_PRIORITY_EN: on a tie, exit always wins
// (frees space first); otherwise ties are broken round-robin.
module parking_gate_arbiter #(
  parameter int unsigned CAP         = 8,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned OPEN_CYCLES = 20
) (
  input  logic                  clk_2Hz,
  input  logic                  reset,
  parking_gate_arbiter_if.slave bus
);

  localparam int unsigned      CW      = $clog2(OPEN_CYCLES);
  localparam logic [CW-1:0]    CntLast = CW'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CapVal  = CNT_W'(CAP);

  typedef enum logic [1:0] {StIdle, StOpen, StGuard} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CNT_W-1:0] occ_q;
  logic             door_open_q;
  logic             grant_entry_q;
  logic             grant_exit_q;
  logic             entry_reject_q;
  logic             busy_q;
`ifndef PARKING_GATE_EXIT_PRIORITY_EN
  logic             last_exit_q;  // 1: exit was served last, so entry wins the next tie
`endif

  logic full;
  logic empty;
  logic entry_elig;
  logic exit_elig;
  logic serve_entry;
  logic serve_exit;

  // Capacity flags straight from the occupancy register.
  always_comb begin
    full  = (occ_q == CapVal);
    empty = (occ_q == '0);
  end

  // Eligibility and tie-break between the two lanes.
  always_comb begin
    entry_elig = bus.entry_req && !full;
    exit_elig  = bus.exit_req && !empty;
`ifdef PARKING_GATE_EXIT_PRIORITY_EN
    serve_exit = exit_elig;
`else
    serve_exit = exit_elig && (!entry_elig || !last_exit_q);
`endif
    serve_entry = entry_elig && !serve_exit;
  end

  // Door sequencing FSM with registered pulse/status outputs and occupancy count.
  always_ff @(posedge clk_2Hz) begin
    if (!reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      occ_q          <= '0;
      door_open_q    <= 1'b0;
      grant_entry_q  <= 1'b0;
      grant_exit_q   <= 1'b0;
      entry_reject_q <= 1'b0;
      busy_q         <= 1'b0;
`ifndef PARKING_GATE_EXIT_PRIORITY_EN
      last_exit_q    <= 1'b1;
`endif
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      door_open_q    <= 1'b0;
      grant_entry_q  <= 1'b0;
      grant_exit_q   <= 1'b0;
      entry_reject_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (serve_entry || serve_exit) begin
            state_q       <= StOpen;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
            door_open_q   <= 1'b1;
            grant_entry_q <= serve_entry;
            grant_exit_q  <= serve_exit;
`ifndef PARKING_GATE_EXIT_PRIORITY_EN
            last_exit_q   <= serve_exit;
`endif
            // Grants are gated by full/empty, so this never wraps.
            occ_q <= serve_entry ? occ_q + 1'b1 : occ_q - 1'b1;
          end else if (bus.entry_req && full) begin
            entry_reject_q <= 1'b1;
          end
        end
        StOpen: begin
          if (cnt_q == CntLast) begin
            state_q <= StGuard;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGuard: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.door_open    = door_open_q;
  assign bus.grant_entry  = grant_entry_q;
  assign bus.grant_exit   = grant_exit_q;
  assign bus.entry_reject = entry_reject_q;
  assign bus.busy         = busy_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.occupancy    = occ_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: directed scenarios then random requests, every cycle
// compared against a timestamp-based reference model of the door schedule.
module tb_parking_gate_arbiter;

  localparam int CAP  = 8;
  localparam int OPEN = 20;

  logic clk_2Hz = 1'b0;
  logic reset;

  always #5 clk_2Hz = ~clk_2Hz;

  parking_gate_arbiter_if #(.CNT_W(4)) bus ();

  parking_gate_arbiter #(
    .CAP        (CAP),
    .CNT_W      (4),
    .OPEN_CYCLES(OPEN)
  ) dut (
    .clk_2Hz(clk_2Hz),
    .reset  (reset),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: occupancy, last side served, edge of last grant.
  int e       = 0;
  int m_occ   = 0;
  bit m_last_exit = 1'b1;
  int m_grant = -1000;
  bit exp_door, exp_ge, exp_gx, exp_rej, exp_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock edge of the reference model, using the inputs sampled at that edge.
  task automatic model_edge();
    bit idle, eo, xo, se, sx;
    e++;
    if (!reset) begin
      m_occ = 0; m_last_exit = 1'b1; m_grant = -1000;
      exp_door = 0; exp_ge = 0; exp_gx = 0; exp_rej = 0;
    end else begin
      idle = (e - m_grant) >= OPEN + 2;
      eo = bus.entry_req && (m_occ < CAP);
      xo = bus.exit_req && (m_occ > 0);
      sx = 0; se = 0;
      if (idle) begin
`ifdef PARKING_GATE_EXIT_PRIORITY_EN
        sx = xo;
`else
        sx = xo && (!eo || !m_last_exit);
`endif
        se = eo && !sx;
      end
      exp_ge = se; exp_gx = sx; exp_door = se || sx;
      exp_rej = idle && bus.entry_req && (m_occ == CAP) && !sx;
      if (se || sx) begin
        m_grant = e; m_last_exit = sx; m_occ = m_occ + (se ? 1 : -1);
      end
    end
    exp_busy = (e - m_grant) <= OPEN;
  endtask

  task automatic step();
    @(posedge clk_2Hz);
    model_edge();
    @(negedge clk_2Hz);
    check("door_open", bus.door_open, exp_door);
    check("grant_entry", bus.grant_entry, exp_ge);
    check("grant_exit", bus.grant_exit, exp_gx);
    check("entry_reject", bus.entry_reject, exp_rej);
    check("busy", bus.busy, exp_busy);
    check("full", bus.full, m_occ == CAP);
    check("empty", bus.empty, m_occ == 0);
    check("occupancy", bus.occupancy, m_occ);
  endtask

  // Hold the requested levels, dropping each one as soon as it is granted.
  task automatic serve(input bit want_en, input bit want_ex);
    bit pend_en, pend_ex;
    pend_en = want_en; pend_ex = want_ex;
    bus.entry_req = pend_en; bus.exit_req = pend_ex;
    for (int i = 0; i < 100 && (pend_en || pend_ex); i++) begin
      step();
      if (bus.grant_entry) pend_en = 0;
      if (bus.grant_exit) pend_ex = 0;
      bus.entry_req = pend_en; bus.exit_req = pend_ex;
    end
    check("serve_done", {pend_en, pend_ex}, 0);
  endtask

  initial begin
    int n, grants, pe, px;
    bit order [3];
    reset = 1'b0;
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;

    // Reset for two cycles then release.
    step(); step();
    reset = 1'b1;
    step();
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_busy", bus.busy, 0);

    // Single entry; then let the door window run out.
    serve(1, 0);
    check("single_occ", bus.occupancy, 1);
    for (int i = 0; i < 25; i++) step();

    // Fill the lot.
    for (int i = 0; i < 12 && !bus.full; i++) serve(1, 0);
    check("fill_occ", bus.occupancy, CAP);
    for (int i = 0; i < 25; i++) step();

    // Entry while full: reject every idle cycle, no door.
    bus.entry_req = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.entry_reject && !bus.door_open) n++;
    end
    check("full_rejects", n, 5);
    // Exit frees a space; the held entry follows.
    serve(1, 1);
    check("after_full_occ", bus.occupancy, CAP);

    // Empty down to 3, then tie with both held for three grants.
    for (int i = 0; i < 10 && bus.occupancy > 3; i++) serve(0, 1);
    for (int i = 0; i < 25; i++) step();
    bus.entry_req = 1'b1; bus.exit_req = 1'b1;
    grants = 0;
    for (int i = 0; i < 100 && grants < 3; i++) begin
      step();
      if (bus.grant_entry || bus.grant_exit) begin
        order[grants] = bus.grant_exit;
        grants++;
      end
    end
    bus.entry_req = 1'b0; bus.exit_req = 1'b0;
    check("tie_count", grants, 3);
`ifdef PARKING_GATE_EXIT_PRIORITY_EN
    check("tie_order0", order[0], 1);
    check("tie_order1", order[1], 1);
    check("tie_order2", order[2], 1);
`else
    check("tie_order0", order[0], 0);
    check("tie_order1", order[1], 1);
    check("tie_order2", order[2], 0);
    check("tie_occ", bus.occupancy, 4);
`endif

    // Drain, then exit on an empty lot must do nothing.
    for (int i = 0; i < 10 && bus.occupancy != 0; i++) serve(0, 1);
    for (int i = 0; i < 25; i++) step();
    bus.exit_req = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.door_open || bus.grant_exit || bus.busy) n++;
    end
    bus.exit_req = 1'b0;
    check("empty_no_grant", n, 0);

    // Reset in the middle of the door window.
    serve(1, 0);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_occ", bus.occupancy, 0);
    step();

    // Random requests with phase-varying bias and occasional reset.
    pe = 50; px = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        pe = 10 + 40 * $urandom_range(0, 2);
        px = 10 + 40 * $urandom_range(0, 2);
      end
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      bus.entry_req = ($urandom_range(0, 99) < pe);
      bus.exit_req  = ($urandom_range(0, 99) < px);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
